sha256_round_engine: RTL and testbench

//  Downstream consumer of the SHA-256 message-schedule pipeline: takes one W[t] word per round and runs the 64

---
 rtl/sha256_round_engine.sv | 139 +++++++++++++
 tb/tb_sha256_round_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_engine.sv
// SHA-256 compression round engine: consumes one schedule word per round,
// runs the rounds on a..h, folds the result into H0..H7 and flags the digest.
module sha256_round_engine #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hash_init,
  input  logic         chunk_start,
  input  logic         w_valid_i,
  input  logic [31:0]  w_i,
  output logic         w_ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] digest_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned NVARS  = 8;

  localparam logic [WORD_W-1:0] IV [NVARS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    t_q;
  logic [WORD_W-1:0]   v_q [NVARS];
  logic [WORD_W-1:0]   h_q [NVARS];

  logic                init_en_c, start_en_c, round_en_c, final_en_c, last_round_c;
  logic [WORD_W-1:0]   s0_c, s1_c, ch_c, maj_c, t1_c, t2_c;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Single-round arithmetic on the current working variables and W[t].
  always_comb begin
    s1_c  = ror(v_q[4], 6) ^ ror(v_q[4], 11) ^ ror(v_q[4], 25);
    ch_c  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    t1_c  = v_q[7] + s1_c + ch_c + K_TAB[t_q] + w_i;
    s0_c  = ror(v_q[0], 2) ^ ror(v_q[0], 13) ^ ror(v_q[0], 22);
    maj_c = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t2_c  = s0_c + maj_c;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath enables; control pulses only count in IDLE.
  always_comb begin
    state_d      = state_q;
    init_en_c    = 1'b0;
    start_en_c   = 1'b0;
    round_en_c   = 1'b0;
    final_en_c   = 1'b0;
    last_round_c = (t_q == CNT_W'(NUM_ROUNDS - 1));
    case (state_q)
      S_IDLE: begin
        init_en_c  = hash_init;
        start_en_c = chunk_start;
        if (chunk_start) state_d = S_ROUND;
      end
      S_ROUND: begin
        round_en_c = w_valid_i;
        if (w_valid_i && last_round_c) state_d = S_FINAL;
      end
      S_FINAL: begin
        final_en_c = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Working variables, chaining state, round counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q    <= '0;
      done_o <= 1'b0;
      for (int unsigned i = 0; i < NVARS; i++) begin
        v_q[i] <= '0;
        h_q[i] <= IV[i];
      end
    end else begin
      done_o <= final_en_c;
      if (init_en_c) begin
        for (int unsigned i = 0; i < NVARS; i++) h_q[i] <= IV[i];
      end
      if (start_en_c) begin
        t_q <= '0;
        // A simultaneous hash_init seeds the rounds from the IV, not the old chain.
        for (int unsigned i = 0; i < NVARS; i++) v_q[i] <= hash_init ? IV[i] : h_q[i];
      end
      if (round_en_c) begin
        v_q[7] <= v_q[6];
        v_q[6] <= v_q[5];
        v_q[5] <= v_q[4];
        v_q[4] <= v_q[3] + t1_c;
        v_q[3] <= v_q[2];
        v_q[2] <= v_q[1];
        v_q[1] <= v_q[0];
        v_q[0] <= t1_c + t2_c;
        t_q    <= t_q + CNT_W'(1);
      end
      if (final_en_c) begin
        t_q <= '0;
        for (int unsigned i = 0; i < NVARS; i++) h_q[i] <= h_q[i] + v_q[i];
      end
    end
  end

  assign w_ready_o = (state_q == S_ROUND);
  assign busy_o    = (state_q != S_IDLE);
  assign digest_o  = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine using known SHA-256 test blocks.
module tb_sha256_round_engine;

  localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hash_init, chunk_start, w_valid_i;
  logic [31:0]  w_i;
  logic         w_ready_o, busy_o, done_o;
  logic [255:0] digest_o;

  typedef struct {
    logic [255:0] dig;
    int           cyc;
    bit           chk;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] msg  [16];
  logic [31:0] wsch [64];

  sha256_round_engine #(.NUM_ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .hash_init(hash_init), .chunk_start(chunk_start),
    .w_valid_i(w_valid_i), .w_i(w_i), .w_ready_o(w_ready_o), .busy_o(busy_o),
    .done_o(done_o), .digest_o(digest_o)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Load one of the padded test blocks and expand its message schedule.
  task automatic set_msg(input int kind);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    case (kind)
      0: begin msg[0] = 32'h61626380; msg[15] = 32'h00000018; end
      1: msg[0] = 32'h80000000;
      2: begin
        msg[0]  = 32'h61626364; msg[1]  = 32'h62636465; msg[2]  = 32'h63646566; msg[3]  = 32'h64656667;
        msg[4]  = 32'h65666768; msg[5]  = 32'h66676869; msg[6]  = 32'h6768696a; msg[7]  = 32'h68696a6b;
        msg[8]  = 32'h696a6b6c; msg[9]  = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
        msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000;
      end
      default: msg[15] = 32'h000001c0;
    endcase
    for (int i = 0; i < 16; i++) wsch[i] = msg[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(wsch[i-15], 7) ^ rr(wsch[i-15], 18) ^ (wsch[i-15] >> 3);
      s1 = rr(wsch[i-2], 17) ^ rr(wsch[i-2], 19) ^ (wsch[i-2] >> 10);
      wsch[i] = s1 + wsch[i-7] + s0 + wsch[i-16];
    end
  endtask

  function automatic int gapf(input int i);
    return (i % 7 == 2) ? 1 : ((i % 13 == 5) ? 2 : 0);
  endfunction

  // Issue one chunk; returns in the FINAL cycle so the next call starts in the done cycle.
  task automatic run_chunk(input bit init, input bit gaps, input bit pulse10, input int abort_at,
                           input bit chk_dig, input logic [255:0] expd);
    int   n = 0;
    int   rdy = 0;
    exp_t e;
    if (gaps) for (int i = 0; i < 64; i++) n += gapf(i);
    @(posedge clk); #1;
    chunk_start = 1'b1;
    hash_init   = init;
    if (abort_at < 0) begin
      e.dig = expd; e.cyc = cyc + 66 + n; e.chk = chk_dig;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    chunk_start = 1'b0;
    hash_init   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0; w_valid_i = 1'b0;
        #1;
        chk("abort_busy", 256'(busy_o), 256'(0));
        chk("abort_done", 256'(done_o), 256'(0));
        chk("abort_ready", 256'(w_ready_o), 256'(0));
        chk("abort_digest", digest_o, IV_D);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int g = 0; g < (gaps ? gapf(i) : 0); g++) begin
        w_valid_i = 1'b0; w_i = 32'hdeadbeef;
        @(negedge clk); if (w_ready_o) rdy++;
        @(posedge clk); #1;
      end
      w_valid_i = 1'b1; w_i = wsch[i];
      if (pulse10 && i == 10) begin chunk_start = 1'b1; hash_init = 1'b1; end
      @(negedge clk); if (w_ready_o) rdy++;
      @(posedge clk); #1;
      chunk_start = 1'b0; hash_init = 1'b0;
    end
    w_valid_i = 1'b0;
    chk("ready_cycles", 256'(rdy), 256'(64 + n));
    @(negedge clk);
    chk("final_ready", 256'(w_ready_o), 256'(0));
    chk("final_busy", 256'(busy_o), 256'(1));
  endtask

  // Scoreboard monitor: pops an expectation at every done pulse.
  task automatic monitor();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        chk("done_single", 256'(prev), 256'(0));
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done actual=done_o=1 required=no pending chunk at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 256'(cyc), 256'(e.cyc));
          if (e.chk) chk("digest", digest_o, e.dig);
        end
      end
      prev = done_o;
    end
  endtask

  initial begin
    rst_n = 1'b0; hash_init = 1'b0; chunk_start = 1'b0; w_valid_i = 1'b0; w_i = 32'h0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_digest", digest_o, IV_D);
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_done", 256'(done_o), 256'(0));
    chk("rst_ready", 256'(w_ready_o), 256'(0));
    w_valid_i = 1'b1;
    @(negedge clk);
    chk("idle_ready", 256'(w_ready_o), 256'(0));
    w_valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_msg(0); run_chunk(1'b1, 1'b0, 1'b0, -1, 1'b1, ABC_D);
    set_msg(1); run_chunk(1'b1, 1'b0, 1'b0, -1, 1'b1, EMPTY_D);

    // hash_init alone in IDLE restores the IV.
    repeat (2) @(posedge clk); #1;
    hash_init = 1'b1;
    @(posedge clk); #1;
    hash_init = 1'b0;
    @(negedge clk);
    chk("hash_init_iv", digest_o, IV_D);

    set_msg(2); run_chunk(1'b1, 1'b0, 1'b0, -1, 1'b0, 256'h0);
    set_msg(3); run_chunk(1'b0, 1'b0, 1'b0, -1, 1'b1, TWO_D);
    repeat (2) @(posedge clk);

    set_msg(0); run_chunk(1'b1, 1'b1, 1'b0, -1, 1'b1, ABC_D);
    repeat (2) @(posedge clk);
    run_chunk(1'b1, 1'b0, 1'b1, -1, 1'b1, ABC_D);
    repeat (2) @(posedge clk);
    run_chunk(1'b1, 1'b0, 1'b0, 30, 1'b0, 256'h0);
    repeat (2) @(posedge clk);
    run_chunk(1'b0, 1'b0, 1'b0, -1, 1'b1, ABC_D);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("pending_done", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
